// File: rtl/ibex_fetch_fifo_hw_if.sv
// Handshake bundle for the halfword-granular fetch FIFO.
//   master : fetch side + ID side as seen by the environment (drives clear,
//            fetch words and out_ready; observes everything the FIFO produces)
//   slave  : the FIFO itself
// Signals: clear_i/clear_addr_i (flush + new PC), in_valid_i/in_ready_o/
// in_rdata_i/in_err_i (fetch word), out_valid_o/out_ready_i/out_addr_o/
// out_rdata_o/out_err_o/out_err_plus2_o (instruction), level_o (halfwords held).
interface ibex_fetch_fifo_hw_if #(
    parameter int unsigned BusW  = 32,
    parameter int unsigned Depth = 3
);
    localparam int unsigned LevelW = $clog2(Depth * (BusW / 16) + 1);

    logic              clear_i;
    logic [31:0]       clear_addr_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [BusW-1:0]   in_rdata_i;
    logic              in_err_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       out_addr_o;
    logic [31:0]       out_rdata_o;
    logic              out_err_o;
    logic              out_err_plus2_o;
    logic [LevelW-1:0] level_o;

    modport master (
        output clear_i, clear_addr_i, in_valid_i, in_rdata_i, in_err_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_addr_o, out_rdata_o, out_err_o,
               out_err_plus2_o, level_o
    );

    modport slave (
        input  clear_i, clear_addr_i, in_valid_i, in_rdata_i, in_err_i, out_ready_i,
        output in_ready_o, out_valid_o, out_addr_o, out_rdata_o, out_err_o,
               out_err_plus2_o, level_o
    );
endinterface

// File: rtl/ibex_fetch_fifo_hw.sv
// Halfword-granular instruction fetch FIFO.
// Accepts BusW-bit fetch words (32 or 64) into a circular buffer of
// Depth*BusW/16 halfwords and presents one realigned RISC-V instruction
// (compressed or uncompressed) per cycle together with its PC.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : clear/new PC, fetch word ready/valid, instruction
//                   ready/valid with addr/rdata/err/err_plus2, fill level
// The interface must be instantiated with the same BusW/Depth as this module.

// One halfword storage cell (16b data + error flag).
module ibex_fetch_fifo_hw_cell #(
    parameter bit ResetAll = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [15:0] data_i,
    input  logic        err_i,
    output logic [15:0] data_o,
    output logic        err_o
);
    if (ResetAll) begin : g_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_o <= '0;
                err_o  <= 1'b0;
            end else if (we_i) begin
                data_o <= data_i;
                err_o  <= err_i;
            end
        end
    end else begin : g_norst
        logic unused_rst;
        assign unused_rst = rst_ni;
        always_ff @(posedge clk_i) begin
            if (we_i) begin
                data_o <= data_i;
                err_o  <= err_i;
            end
        end
    end
endmodule

module ibex_fetch_fifo_hw #(
    parameter int unsigned BusW     = 32,
    parameter int unsigned Depth    = 3,
    parameter bit          ResetAll = 1'b0
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    ibex_fetch_fifo_hw_if.slave bus
);
    localparam int unsigned HPW = BusW / 16;
    localparam int unsigned CAP = Depth * HPW;
    localparam int unsigned PW  = $clog2(CAP);
    localparam int unsigned CW  = $clog2(CAP + 1);
    localparam int unsigned SW  = $clog2(HPW);

    if (!(BusW == 32 || BusW == 64)) begin : g_bad_busw
        $error("ibex_fetch_fifo_hw: BusW must be 32 or 64");
    end
    if (Depth < 2) begin : g_bad_depth
        $error("ibex_fetch_fifo_hw: Depth must be >= 2");
    end

    // Pointer increment modulo CAP; inc never exceeds HPW <= CAP.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [2:0] inc);
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(inc);
        if (s >= (PW+1)'(CAP)) s = s - (PW+1)'(CAP);
        return s[PW-1:0];
    endfunction

    logic [PW-1:0]         rd_ptr_q, wr_ptr_q, rd_ptr1;
    logic [CW-1:0]         count_q;
    logic [30:0]           pc_q;
    logic [SW-1:0]         skip_q;

    logic [CAP-1:0]        cell_we;
    logic [CAP-1:0][15:0]  cell_wdata, cell_rdata;
    logic [CAP-1:0]        cell_rerr;

    logic                  push, pop, cmp;
    logic [15:0]           hw0, hw1;
    logic                  hw0_err, hw1_err, cnt_ge1, cnt_ge2;
    logic [2:0]            push_n, pop_n;
    logic                  unused_addr0;

    assign unused_addr0 = bus.clear_addr_i[0];

    // ---------------- input side ----------------
    // Readiness looks only at the registered count, so a pop in the same
    // cycle never widens the window.
    assign bus.in_ready_o = (count_q <= CW'(CAP - HPW));
    assign push   = bus.in_valid_i & bus.in_ready_o & ~bus.clear_i;
    assign push_n = push ? (3'(HPW) - 3'(skip_q)) : 3'd0;

    // Lanes below skip_q belong to addresses before the branch target and are
    // dropped; the rest pack down starting at wr_ptr.
    always_comb begin
        cell_we    = '0;
        cell_wdata = '0;
        for (int h = 0; h < int'(HPW); h++) begin
            if (push && (h >= int'(skip_q))) begin
                cell_we[ptr_add(wr_ptr_q, 3'(h - int'(skip_q)))]    = 1'b1;
                cell_wdata[ptr_add(wr_ptr_q, 3'(h - int'(skip_q)))] = bus.in_rdata_i[h*16 +: 16];
            end
        end
    end

    for (genvar e = 0; e < int'(CAP); e++) begin : g_cell
        ibex_fetch_fifo_hw_cell #(.ResetAll(ResetAll)) u_cell (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .we_i   (cell_we[e]),
            .data_i (cell_wdata[e]),
            .err_i  (bus.in_err_i),
            .data_o (cell_rdata[e]),
            .err_o  (cell_rerr[e])
        );
    end

    // ---------------- output side ----------------
    assign rd_ptr1 = ptr_add(rd_ptr_q, 3'd1);
    assign hw0     = cell_rdata[rd_ptr_q];
    assign hw0_err = cell_rerr[rd_ptr_q];
    assign hw1     = cell_rdata[rd_ptr1];
    assign hw1_err = cell_rerr[rd_ptr1];
    assign cnt_ge1 = (count_q != '0);
    assign cnt_ge2 = (count_q >= CW'(2));

    // An erroneous first halfword is reported on its own: its opcode bits
    // are meaningless, so it is treated as a one-halfword unit.
    assign cmp = (hw0[1:0] != 2'b11) & ~hw0_err;

    assign bus.out_valid_o     = cnt_ge1 & (cmp | hw0_err | cnt_ge2);
    assign bus.out_rdata_o     = {hw1, hw0};
    assign bus.out_err_o       = hw0_err | (~cmp & cnt_ge2 & hw1_err);
    assign bus.out_err_plus2_o = ~hw0_err & ~cmp & hw1_err;
    assign bus.out_addr_o      = {pc_q, 1'b0};
    assign bus.level_o         = count_q;

    assign pop   = bus.out_valid_o & bus.out_ready_i & ~bus.clear_i;
    assign pop_n = pop ? ((cmp | hw0_err) ? 3'd1 : 3'd2) : 3'd0;

    // ---------------- state ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= '0;
            skip_q   <= '0;
        end else if (bus.clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= bus.clear_addr_i[31:1];
            // Halfword offset of the target inside its fetch word.
            skip_q   <= bus.clear_addr_i[SW:1];
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_add(wr_ptr_q, push_n);
                skip_q   <= '0;
            end
            if (pop) begin
                rd_ptr_q <= ptr_add(rd_ptr_q, pop_n);
                pc_q     <= pc_q + 31'(pop_n);
            end
            count_q <= count_q + CW'(push_n) - CW'(pop_n);
        end
    end

`ifndef SYNTHESIS
    a_count_cap : assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CW'(CAP));

    a_hold_lo : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.out_valid_o && !bus.out_ready_i && !bus.clear_i)
        |=> ($stable(bus.out_addr_o) && $stable(bus.out_rdata_o[15:0])));

    // The upper half is only settled once a second halfword is resident.
    a_hold_hi : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.out_valid_o && !bus.out_ready_i && !bus.clear_i && cnt_ge2)
        |=> $stable(bus.out_rdata_o));
`endif
endmodule

// File: doc/ibex_fetch_fifo_hw.md
Name: ibex_fetch_fifo_hw

Overview:
Parametrised halfword-granular instruction fetch FIFO. It sits between the prefetch bus interface and the ID stage. It accepts fetch words of BusW bits (32 or 64) into a circular buffer of Depth words, realigns compressed (16-bit) and uncompressed (32-bit) RISC-V instructions, and presents one instruction per cycle with its PC. It adds the following beyond the fixed 32-bit fetch FIFO:
- selectable bus width
- ready/valid back-pressure on the input instead of "never push when full"
- a fill-level output
- discard of leading halfwords when the branch target is not word-aligned

Parameters:
BusW, 32, fetch word width in bits; legal values 32 or 64. HPW = BusW/16 halfwords per word.
Depth, 3, buffer capacity in fetch words; must be >= 2. CAP = Depth*HPW halfwords.
ResetAll, 0, 1 = data/err storage has async reset to 0; 0 = data/err storage is not reset.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  flush the buffer and load a new PC
clear_addr_i  in  32  new PC loaded on clear (bit 0 ignored)
in_valid_i  in  1  fetch word valid
in_ready_o  out  1  FIFO can accept a full word
in_rdata_i  in  BusW  fetch word, little-endian halfwords
in_err_i  in  1  bus error for the whole word
out_valid_o  out  1  complete instruction available
out_ready_i  in  1  consumer takes the instruction
out_addr_o  out  32  PC of the presented instruction, bit 0 = 0
out_rdata_o  out  32  instruction; [15:0] = first halfword
out_err_o  out  1  fetch error for the presented instruction
out_err_plus2_o  out  1  error lies only in the second halfword
level_o  out  $clog2(CAP+1)  halfwords currently stored

Behaviour:
- State:
  - halfword array buf[CAP] (16b data + 1b err)
  - rd_ptr, wr_ptr: modulo CAP, wrap from CAP-1 to 0
  - count: 0..CAP
  - pc_q[31:1]
  - skip_q: number of halfwords to discard, width log2(HPW), 0 for BusW=32 via bit [1]
- Reset values:
  - count=0, pointers=0, pc_q=0, skip_q=0
  - out_valid_o=0, in_ready_o=1, level_o=0, out_addr_o=0
- Input handshake:
  - in_ready_o = (CAP-count) >= HPW. Computed from registered count only; it does not depend on a same-cycle pop.
  - Push = in_valid_i & in_ready_o & ~clear_i.
  - On push, halfwords skip_q..HPW-1 of in_rdata_i are written at wr_ptr upward (wrapping), each with err=in_err_i. wr_ptr and count advance by HPW-skip_q; skip_q is then cleared to 0.
- Output (combinational from registered state; no bypass, so push-to-out_valid latency is 1 cycle):
  - hw0 = buf[rd_ptr], hw1 = buf[rd_ptr+1 mod CAP].
  - cmp = (hw0.data[1:0] != 2'b11) & ~hw0.err.
  - out_valid_o = (count>=1) & (cmp | hw0.err | count>=2).
  - out_rdata_o = {hw1.data, hw0.data}. The upper half is don't-care when cmp.
  - out_err_o = hw0.err | (~cmp & count>=2 & hw1.err).
  - out_err_plus2_o = ~hw0.err & ~cmp & hw1.err.
  - out_addr_o = {pc_q, 1'b0}.
- Pop = out_valid_o & out_ready_i & ~clear_i.
  - Pop size n = 1 if (cmp | hw0.err), else 2.
  - rd_ptr += n (mod CAP), count -= n, pc_q += n. pc_q wraps at 2^31.
- Simultaneous push and pop: count_next = count + pushed - n. Both take effect in the same cycle.
- Clear (highest priority, overrides push and pop):
  - Next cycle: count=0, rd_ptr=wr_ptr=0, pc_q=clear_addr_i[31:1].
  - skip_q = clear_addr_i[log2(BusW/8)-1:1].
  - A word presented in the clear cycle is dropped. The first word accepted afterwards must be the word containing clear_addr_i.
- level_o = count.
- Elaboration: $error if BusW not in {32,64} or Depth<2.
- Assertions:
  - count never exceeds CAP.
  - out_valid_o held with out_ready_i low keeps out_addr_o/out_rdata_o stable unless clear_i.

Test Plan:
1. BusW=32: clear 0x100, push 0x00138093 → next cycle out_valid_o=1, out_rdata_o=0x00138093, out_addr_o=0x100, level_o=2. Pop → out_addr_o=0x104, level_o=0, out_valid_o=0.
2. Compressed pair: clear 0x200, push 0x40014501 → out [15:0]=0x4501 at 0x200; pop → out [15:0]=0x4001 at 0x202; pop → level_o=0.
3. Straddle: clear 0x102, push 0x80930000 → out_valid_o=0, level_o=1. Push 0x00000013 → out_rdata_o=0x00138093, out_addr_o=0x102, level_o=3.
4. Error in second half: as test 3 but second word with in_err_i=1 → out_err_o=1, out_err_plus2_o=1. Pop advances out_addr_o by 4 (to 0x106).
5. Full (BusW=64, Depth=3): three pushes, no pops → level_o=12, in_ready_o=0. A 4th in_valid_i is not accepted. One compressed pop → level_o=11, in_ready_o still 0. Three more compressed pops → level_o=8, in_ready_o=1.
6. Clear mid-operation: level_o=4, assert clear_i (addr 0x306) with in_valid_i=1 and out_ready_i=1 → next cycle level_o=0, out_addr_o=0x306, no pop/push effect. Push a 64-bit word → only halfword 3 stored, level_o=1.
